// File: rtl/conv_engine.sv
// 3x3 zero-padded, same-size convolution over an NxN word map. Weights and
// IFM are fetched and OFM written through a single-outstanding memory port.
module conv_engine #(
  parameter int unsigned DIM_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] fm_dim_i,
  input  logic [31:0] ifm_offset_i,
  input  logic [31:0] wt_offset_i,
  input  logic [31:0] ofm_offset_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic        req_we_o,
  output logic [31:0] req_addr_o,
  output logic [31:0] req_wdata_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_data_i,
  output logic        idle_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_WT, S_LD_WAIT, S_TAP, S_RD_REQ, S_RD_WAIT, S_WR, S_DONE
  } state_t;

  state_t           r_state;
  logic [DIM_W-1:0] r_dim;
  logic [DIM_W-1:0] r_row;
  logic [DIM_W-1:0] r_col;
  logic [3:0]       r_k;
  logic [31:0]      r_ifm_base;
  logic [31:0]      r_wt_base;
  logic [31:0]      r_ofm_base;
  logic [31:0]      r_wt [0:8];
  logic [31:0]      r_acc;
  logic             r_req_valid;
  logic             r_req_we;
  logic [31:0]      r_req_addr;
  logic [31:0]      r_req_wdata;
  logic             r_idle;
  logic             r_done;

  logic             w_row_dec;
  logic             w_row_inc;
  logic             w_col_dec;
  logic             w_col_inc;
  logic             w_last_row;
  logic             w_last_col;
  logic             w_pad;
  logic [31:0]      w_dim;
  logic [31:0]      w_in_row;
  logic [31:0]      w_in_col;
  logic [31:0]      w_tap_addr;
  logic [31:0]      w_out_addr;
  logic [31:0]      w_wt_addr;
  logic [31:0]      w_prod;
  logic             w_unused_dim;

  assign w_unused_dim = ^fm_dim_i;

  // Tap k maps to (dr, dc) = (k/3 - 1, k%3 - 1); decoded as +/-1 flags.
  always_comb begin
    w_row_dec = (r_k <= 4'd2);
    w_row_inc = (r_k >= 4'd6);
    w_col_dec = (r_k == 4'd0) || (r_k == 4'd3) || (r_k == 4'd6);
    w_col_inc = (r_k == 4'd2) || (r_k == 4'd5) || (r_k == 4'd8);
  end

  assign w_dim      = 32'(r_dim);
  assign w_last_row = (r_row == r_dim - DIM_W'(1));
  assign w_last_col = (r_col == r_dim - DIM_W'(1));
  assign w_pad      = (w_row_dec && (r_row == '0)) || (w_row_inc && w_last_row) ||
                      (w_col_dec && (r_col == '0)) || (w_col_inc && w_last_col);

  assign w_in_row   = 32'(r_row) + (w_row_inc ? 32'd1 : 32'd0) - (w_row_dec ? 32'd1 : 32'd0);
  assign w_in_col   = 32'(r_col) + (w_col_inc ? 32'd1 : 32'd0) - (w_col_dec ? 32'd1 : 32'd0);
  assign w_tap_addr = r_ifm_base + ((w_in_row * w_dim + w_in_col) << 2);
  assign w_out_addr = r_ofm_base + ((32'(r_row) * w_dim + 32'(r_col)) << 2);
  assign w_wt_addr  = r_wt_base + (32'(r_k) << 2);
  assign w_prod     = r_wt[r_k] * resp_data_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dim       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_k         <= '0;
      r_ifm_base  <= '0;
      r_wt_base   <= '0;
      r_ofm_base  <= '0;
      r_acc       <= '0;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_idle      <= 1'b1;
      r_done      <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) r_wt[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_dim      <= fm_dim_i[DIM_W-1:0];
            r_ifm_base <= ifm_offset_i;
            r_wt_base  <= wt_offset_i;
            r_ofm_base <= ofm_offset_i;
            r_row      <= '0;
            r_col      <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            if (fm_dim_i[DIM_W-1:0] == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_idle  <= 1'b1;
            end else begin
              r_state <= S_LD_WT;
              r_done  <= 1'b0;
              r_idle  <= 1'b0;
            end
          end
        end

        S_LD_WT: begin
          if (!r_req_valid) begin
            r_req_valid <= 1'b1;
            r_req_we    <= 1'b0;
            r_req_addr  <= w_wt_addr;
          end else if (req_ready_i) begin
            r_req_valid <= 1'b0;
            r_state     <= S_LD_WAIT;
          end
        end

        S_LD_WAIT: begin
          if (resp_valid_i) begin
            r_wt[r_k] <= resp_data_i;
            if (r_k == 4'd8) begin
              r_k     <= '0;
              r_state <= S_TAP;
            end else begin
              r_k     <= r_k + 4'd1;
              r_state <= S_LD_WT;
            end
          end
        end

        S_TAP: begin
          if (w_pad) begin
            if (r_k == 4'd8) r_state <= S_WR;
            else             r_k     <= r_k + 4'd1;
          end else begin
            r_req_valid <= 1'b1;
            r_req_we    <= 1'b0;
            r_req_addr  <= w_tap_addr;
            r_state     <= S_RD_REQ;
          end
        end

        S_RD_REQ: begin
          if (req_ready_i) begin
            r_req_valid <= 1'b0;
            r_state     <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (resp_valid_i) begin
            r_acc <= r_acc + w_prod;
            if (r_k == 4'd8) begin
              r_state <= S_WR;
            end else begin
              r_k     <= r_k + 4'd1;
              r_state <= S_TAP;
            end
          end
        end

        // First cycle registers the write fields from the settled acc, second
        // cycle onward holds them until the handshake.
        S_WR: begin
          if (!r_req_valid) begin
            r_req_valid <= 1'b1;
            r_req_we    <= 1'b1;
            r_req_addr  <= w_out_addr;
            r_req_wdata <= r_acc;
          end else if (req_ready_i) begin
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_acc       <= '0;
            r_k         <= '0;
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_idle  <= 1'b1;
              end else begin
                r_row   <= r_row + DIM_W'(1);
                r_state <= S_TAP;
              end
            end else begin
              r_col   <= r_col + DIM_W'(1);
              r_state <= S_TAP;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_valid_o = r_req_valid;
  assign req_we_o    = r_req_we;
  assign req_addr_o  = r_req_addr;
  assign req_wdata_o = r_req_wdata;
  assign idle_o      = r_idle;
  assign done_o      = r_done;

endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: every job queues its expected request stream (weight
// reads, IFM reads, OFM writes) and each request handshake is matched against it.
module tb_conv_engine;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] fm_dim_i;
  logic [31:0] ifm_offset_i;
  logic [31:0] wt_offset_i;
  logic [31:0] ofm_offset_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic        resp_valid_i;
  logic [31:0] resp_data_i;
  logic        idle_o;
  logic        done_o;

  conv_engine #(.DIM_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .fm_dim_i     (fm_dim_i),
    .ifm_offset_i (ifm_offset_i),
    .wt_offset_i  (wt_offset_i),
    .ofm_offset_i (ofm_offset_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_we_o     (req_we_o),
    .req_addr_o   (req_addr_o),
    .req_wdata_o  (req_wdata_o),
    .resp_valid_i (resp_valid_i),
    .resp_data_i  (resp_data_i),
    .idle_o       (idle_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  localparam logic [31:0] WB = 32'h0000_0040;
  localparam logic [31:0] IB = 32'h0000_0100;
  localparam logic [31:0] OB = 32'h0000_0800;

  txn_t        exp_q[$];
  logic [31:0] mem [0:1023];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned n_hs = 0;
  int unsigned n_resp = 0;
  int unsigned t_resp9 = 0;
  int unsigned last_wr_cyc = 0;
  int unsigned exp_cycles = 0;
  bit          rand_ready = 1'b0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned pend = 0;
  logic [31:0] pend_data = '0;
  logic        prev_stall = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    mem[a[11:2]] = d;
  endtask

  // Memory model and request monitor: drives ready/response after each edge,
  // observes the request bus mid-cycle.
  initial begin
    txn_t e;
    req_ready_i  = 1'b1;
    resp_valid_i = 1'b0;
    resp_data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      resp_valid_i = 1'b0;
      if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          resp_valid_i = 1'b1;
          resp_data_i  = pend_data;
          n_resp++;
          if (n_resp == 9) t_resp9 = cyc;
        end
      end
      req_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rst === 1'b0) begin
        if (prev_stall) begin
          checks++;
          if (req_valid_o !== 1'b1 || req_we_o !== prev_we || req_addr_o !== prev_addr ||
              req_wdata_o !== prev_wdata) begin
            failures++;
            $display("FAIL req_stable: got v=%0b we=%0b a=%h d=%h, expected v=1 we=%0b a=%h d=%h",
                     req_valid_o, req_we_o, req_addr_o, req_wdata_o, prev_we, prev_addr, prev_wdata);
          end
        end
        prev_stall = (req_valid_o === 1'b1) && (req_ready_i === 1'b0);
        prev_we    = req_we_o;
        prev_addr  = req_addr_o;
        prev_wdata = req_wdata_o;
        if (req_valid_o === 1'b1 && req_ready_i === 1'b1) begin
          n_hs++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL req_unexpected: got we=%0b a=%h d=%h, expected no request",
                     req_we_o, req_addr_o, req_wdata_o);
          end else begin
            e = exp_q.pop_front();
            if (req_we_o !== e.we || req_addr_o !== e.addr || (e.we && req_wdata_o !== e.data)) begin
              failures++;
              $display("FAIL req_txn: got we=%0b a=%h d=%h, expected we=%0b a=%h d=%h",
                       req_we_o, req_addr_o, req_wdata_o, e.we, e.addr, e.data);
            end
          end
          if (req_we_o === 1'b1) begin
            mem_wr(req_addr_o, req_wdata_o);
            last_wr_cyc = cyc;
          end else begin
            pend_data = mem_rd(req_addr_o);
            pend      = $urandom_range(lat_min, lat_max);
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Golden model: queue the expected request stream, then pulse start.
  task automatic start_job(input int unsigned n, input logic [31:0] wb, input logic [31:0] ib,
                           input logic [31:0] ob, output logic idle_after);
    logic [31:0] acc;
    logic [31:0] xa;
    int          ir;
    int          ic;
    int unsigned interior;
    exp_q.delete();
    interior = 0;
    if (n != 0) begin
      for (int unsigned k = 0; k < 9; k++) exp_q.push_back('{we: 1'b0, addr: wb + 4 * k, data: 32'h0});
      for (int r = 0; r < int'(n); r++) begin
        for (int c = 0; c < int'(n); c++) begin
          acc = '0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              ir = r + dr;
              ic = c + dc;
              if (ir >= 0 && ir < int'(n) && ic >= 0 && ic < int'(n)) begin
                xa  = ib + 32'(4 * (ir * int'(n) + ic));
                acc = acc + mem_rd(wb + 32'(4 * ((dr + 1) * 3 + dc + 1))) * mem_rd(xa);
                interior++;
                exp_q.push_back('{we: 1'b0, addr: xa, data: 32'h0});
              end
            end
          end
          exp_q.push_back('{we: 1'b1, addr: ob + 32'(4 * (r * int'(n) + c)), data: acc});
        end
      end
    end
    exp_cycles = interior * 3 + (9 * n * n - interior) + 2 * n * n;
    @(posedge clk);
    #2;
    fm_dim_i     = n;
    wt_offset_i  = wb;
    ifm_offset_i = ib;
    ofm_offset_i = ob;
    start_i      = 1'b1;
    n_resp       = 0;
    @(posedge clk);
    #2;
    start_i    = 1'b0;
    idle_after = idle_o;
  endtask

  task automatic wait_done(input int unsigned budget, output logic ok, output int unsigned t_done);
    ok = 1'b0;
    t_done = 0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #2;
      if (done_o === 1'b1) begin
        ok = 1'b1;
        t_done = cyc;
      end
    end
  endtask

  task automatic fill_random(input int unsigned n);
    for (int unsigned k = 0; k < 9; k++) mem_wr(WB + 4 * k, $urandom);
    for (int unsigned i = 0; i < n * n; i++) mem_wr(IB + 4 * i, $urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (req_valid_o !== 1'b0 || req_we_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_req_ctrl: got v=%0b we=%0b, expected 0 0", req_valid_o, req_we_o);
    end
    checks++;
    if (req_addr_o !== 32'h0 || req_wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_req_data: got a=%h d=%h, expected 0 0", req_addr_o, req_wdata_o);
    end
    checks++;
    if (idle_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got idle=%0b done=%0b, expected 1 0", idle_o, done_o);
    end
    fm_dim_i = 32'd2;
    start_i  = 1'b1;
    @(posedge clk);
    #2;
    start_i = 1'b0;
    checks++;
    if (idle_o !== 1'b1 || req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_beats_start: got idle=%0b v=%0b, expected 1 0", idle_o, req_valid_o);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (idle_o !== 1'b1 || done_o !== 1'b0 || req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got idle=%0b done=%0b v=%0b, expected 1 0 0",
               idle_o, done_o, req_valid_o);
    end
  endtask

  task automatic test_zero_dim();
    logic        idle_a;
    logic        seen;
    int unsigned hs0;
    hs0 = n_hs;
    start_job(0, WB, IB, OB, idle_a);
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL zero_dim_done: got %0b, expected 1", done_o);
    end
    seen = (idle_a !== 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      if (req_valid_o !== 1'b0 || idle_o !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || n_hs != hs0) begin
      failures++;
      $display("FAIL zero_dim_quiet: got activity=%0b handshakes=%0d, expected 0 0", seen, n_hs - hs0);
    end
  endtask

  task automatic test_single_pixel();
    logic        idle_a;
    logic        ok;
    int unsigned t_done;
    int unsigned hs0;
    for (int unsigned k = 0; k < 9; k++) mem_wr(WB + 4 * k, (k == 4) ? 32'd3 : 32'd7);
    mem_wr(IB, 32'd5);
    mem_wr(OB, 32'h0);
    hs0 = n_hs;
    start_job(1, WB, IB, OB, idle_a);
    checks++;
    if (idle_a !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_drop: got %0b, expected 0", idle_a);
    end
    wait_done(500, ok, t_done);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_done: got done=%0b pending=%0d, expected 1 0", ok, exp_q.size());
    end
    checks++;
    if (mem_rd(OB) !== 32'd15) begin
      failures++;
      $display("FAIL single_value: got %0d, expected 15", mem_rd(OB));
    end
    checks++;
    if (n_hs - hs0 != 11) begin
      failures++;
      $display("FAIL single_req_count: got %0d, expected 11", n_hs - hs0);
    end
    checks++;
    if (t_done != t_resp9 + 1 + exp_cycles || t_done != last_wr_cyc + 1) begin
      failures++;
      $display("FAIL single_timing: got %0d, expected %0d (last write %0d)",
               t_done - t_resp9 - 1, exp_cycles, last_wr_cyc);
    end
  endtask

  task automatic test_ones_3x3();
    logic        idle_a;
    logic        ok;
    int unsigned t_done;
    int unsigned hs0;
    logic [31:0] tbl [9] = '{32'd4, 32'd6, 32'd4, 32'd6, 32'd9, 32'd6, 32'd4, 32'd6, 32'd4};
    for (int unsigned k = 0; k < 9; k++) begin
      mem_wr(WB + 4 * k, 32'd1);
      mem_wr(IB + 4 * k, 32'd1);
      mem_wr(OB + 4 * k, 32'hFFFF_FFFF);
    end
    hs0 = n_hs;
    start_job(3, WB, IB, OB, idle_a);
    wait_done(2000, ok, t_done);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ones_done: got done=%0b pending=%0d, expected 1 0", ok, exp_q.size());
    end
    for (int unsigned i = 0; i < 9; i++) begin
      checks++;
      if (mem_rd(OB + 4 * i) !== tbl[i]) begin
        failures++;
        $display("FAIL ones_ofm[%0d]: got %0d, expected %0d", i, mem_rd(OB + 4 * i), tbl[i]);
      end
    end
    checks++;
    if (n_hs - hs0 != 67) begin
      failures++;
      $display("FAIL ones_req_count: got %0d, expected 67", n_hs - hs0);
    end
    checks++;
    if (t_done != t_resp9 + 1 + 197 || t_done != last_wr_cyc + 1) begin
      failures++;
      $display("FAIL ones_timing: got %0d, expected 197", t_done - t_resp9 - 1);
    end
  endtask

  task automatic test_restart_ignored();
    logic        idle_a;
    logic        ok;
    int unsigned t_done;
    fill_random(3);
    start_job(3, WB, IB, OB, idle_a);
    repeat (40) @(posedge clk);
    #2;
    fm_dim_i     = 32'd2;
    wt_offset_i  = 32'h0000_0200;
    ifm_offset_i = 32'h0000_0300;
    ofm_offset_i = 32'h0000_0400;
    start_i      = 1'b1;
    @(posedge clk);
    #2;
    start_i = 1'b0;
    checks++;
    if (idle_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL restart_busy: got idle=%0b done=%0b, expected 0 0", idle_o, done_o);
    end
    wait_done(2000, ok, t_done);
    checks++;
    if (!ok || exp_q.size() != 0 || idle_o !== 1'b1) begin
      failures++;
      $display("FAIL restart_done: got done=%0b pending=%0d idle=%0b, expected 1 0 1",
               ok, exp_q.size(), idle_o);
    end
  endtask

  task automatic test_random_stall();
    logic        idle_a;
    logic        ok;
    int unsigned t_done;
    fill_random(4);
    rand_ready = 1'b1;
    lat_min    = 1;
    lat_max    = 5;
    start_job(4, WB, IB, OB, idle_a);
    wait_done(20000, ok, t_done);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_done: got done=%0b pending=%0d, expected 1 0", ok, exp_q.size());
    end
    rand_ready = 1'b0;
    lat_max    = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset_mid_job();
    logic        idle_a;
    logic        ok;
    logic        seen_req;
    logic        seen_resp;
    int unsigned t_done;
    int unsigned hs0;
    fill_random(4);
    lat_min = 5;
    lat_max = 5;
    hs0 = n_hs;
    start_job(4, WB, IB, OB, idle_a);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (n_hs >= hs0 + 11) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrst_reach: got %0d handshakes, expected 11", n_hs - hs0);
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2;
    checks++;
    if (req_valid_o !== 1'b0 || idle_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state: got v=%0b idle=%0b done=%0b, expected 0 1 0",
               req_valid_o, idle_o, done_o);
    end
    rst = 1'b0;
    lat_min = 1;
    lat_max = 1;
    seen_req  = 1'b0;
    seen_resp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (req_valid_o !== 1'b0 || idle_o !== 1'b1 || done_o !== 1'b0) seen_req = 1'b1;
      if (resp_valid_i === 1'b1) seen_resp = 1'b1;
    end
    checks++;
    if (seen_req || !seen_resp) begin
      failures++;
      $display("FAIL midrst_late_resp: got activity=%0b late_resp=%0b, expected 0 1", seen_req, seen_resp);
    end
    fill_random(2);
    start_job(2, WB, IB, OB, idle_a);
    wait_done(2000, ok, t_done);
    checks++;
    if (!ok || exp_q.size() != 0 || t_done != t_resp9 + 1 + exp_cycles) begin
      failures++;
      $display("FAIL midrst_rerun: got done=%0b pending=%0d cycles=%0d, expected 1 0 %0d",
               ok, exp_q.size(), t_done - t_resp9 - 1, exp_cycles);
    end
  endtask

  task automatic test_wrap();
    logic        idle_a;
    logic        ok;
    int unsigned t_done;
    for (int unsigned k = 0; k < 9; k++) mem_wr(WB + 4 * k, $urandom);
    mem_wr(WB + 16, 32'd4);
    mem_wr(IB, 32'h4000_0000);
    mem_wr(OB, 32'hDEAD_BEEF);
    start_job(1, WB, IB, OB, idle_a);
    wait_done(500, ok, t_done);
    checks++;
    if (!ok || mem_rd(OB) !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_pos: got done=%0b value=%h, expected 1 00000000", ok, mem_rd(OB));
    end
    mem_wr(WB + 16, 32'd3);
    mem_wr(IB, 32'hFFFF_FFFE);
    mem_wr(OB, 32'h0);
    start_job(1, WB, IB, OB, idle_a);
    wait_done(500, ok, t_done);
    checks++;
    if (!ok || mem_rd(OB) !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL wrap_neg: got done=%0b value=%h, expected 1 fffffffa", ok, mem_rd(OB));
    end
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    fm_dim_i     = '0;
    ifm_offset_i = '0;
    wt_offset_i  = '0;
    ofm_offset_i = '0;
    test_reset();
    test_zero_dim();
    test_single_pixel();
    test_ones_3x3();
    test_restart_ignored();
    test_random_stall();
    test_reset_mid_job();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
